dds_generator: RTL and testbench

Direct digital synthesis sine source driving an external 12-bit SPI DAC (MCP4921-style 16-bit write frame). A phase accumulator advances once per sample tick, addresses a 256-entry sine table, and each new 12-bit sample is shifted out over SPI. It is the top-level signal path between the 125 MHz board clock and the DAC pins. Internal signals `sample_amplitude_2` and `clk_DDS` are kept under these names for hierarchical probing by the bench.

---
 rtl/dds_generator.sv | 161 ++++++++++++++++
 tb/tb_dds_generator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_generator.sv
// DDS sine source: phase accumulator -> sine ROM -> MCP4921-style 16-bit SPI DAC write.
// Build option: define DDS_QUARTER_WAVE_EN to keep only the 65-entry quarter-wave table.
module dds_generator #(
  parameter int                 PHASE_W    = 32,
  parameter logic [PHASE_W-1:0] FTW        = 32'd4294967,
  parameter int                 SAMPLE_DIV = 250,
  parameter int                 SCK_HALF   = 4
) (
  input  logic sysclk,
  input  logic reset,
  output logic spi_mosi,
  output logic spi_sck,
  output logic spi_cs
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int HC_W  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  typedef enum logic {IDLE, SHIFT} spi_state_t;

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_next;
  logic               tick;
  logic [1:0]         tick_q;
  logic               clk_DDS;
  logic               load_sample;
  logic [PHASE_W-1:0] phase_acc;
  logic [7:0]         lut_addr;
  logic [11:0]        lut_data;
  logic [11:0]        sample_amplitude_1;
  logic [11:0]        sample_amplitude_2;
  logic [15:0]        frame_word;
  spi_state_t         state;
  logic [HC_W-1:0]    half_cnt;
  logic [3:0]         bit_cnt;
  logic [3:0]         next_bit;

  // First quadrant: 2048 + round(2047*sin(2*pi*i/256)), i = 0..64.
  function automatic logic [11:0] quarter_sine(input logic [6:0] idx);
    logic [11:0] v;
    case (idx)
      7'd0:  v = 12'd2048; 7'd1:  v = 12'd2098; 7'd2:  v = 12'd2148; 7'd3:  v = 12'd2199;
      7'd4:  v = 12'd2249; 7'd5:  v = 12'd2299; 7'd6:  v = 12'd2348; 7'd7:  v = 12'd2398;
      7'd8:  v = 12'd2447; 7'd9:  v = 12'd2497; 7'd10: v = 12'd2545; 7'd11: v = 12'd2594;
      7'd12: v = 12'd2642; 7'd13: v = 12'd2690; 7'd14: v = 12'd2738; 7'd15: v = 12'd2785;
      7'd16: v = 12'd2831; 7'd17: v = 12'd2878; 7'd18: v = 12'd2923; 7'd19: v = 12'd2968;
      7'd20: v = 12'd3013; 7'd21: v = 12'd3057; 7'd22: v = 12'd3100; 7'd23: v = 12'd3143;
      7'd24: v = 12'd3185; 7'd25: v = 12'd3227; 7'd26: v = 12'd3267; 7'd27: v = 12'd3307;
      7'd28: v = 12'd3347; 7'd29: v = 12'd3385; 7'd30: v = 12'd3423; 7'd31: v = 12'd3459;
      7'd32: v = 12'd3495; 7'd33: v = 12'd3531; 7'd34: v = 12'd3565; 7'd35: v = 12'd3598;
      7'd36: v = 12'd3630; 7'd37: v = 12'd3662; 7'd38: v = 12'd3692; 7'd39: v = 12'd3722;
      7'd40: v = 12'd3750; 7'd41: v = 12'd3777; 7'd42: v = 12'd3804; 7'd43: v = 12'd3829;
      7'd44: v = 12'd3853; 7'd45: v = 12'd3876; 7'd46: v = 12'd3898; 7'd47: v = 12'd3919;
      7'd48: v = 12'd3939; 7'd49: v = 12'd3958; 7'd50: v = 12'd3975; 7'd51: v = 12'd3992;
      7'd52: v = 12'd4007; 7'd53: v = 12'd4021; 7'd54: v = 12'd4034; 7'd55: v = 12'd4045;
      7'd56: v = 12'd4056; 7'd57: v = 12'd4065; 7'd58: v = 12'd4073; 7'd59: v = 12'd4080;
      7'd60: v = 12'd4085; 7'd61: v = 12'd4089; 7'd62: v = 12'd4093; 7'd63: v = 12'd4094;
      default: v = 12'd4095;
    endcase
    return v;
  endfunction

  // Mirror the address in quadrants 1/3 and invert the amplitude in the lower half-wave.
  function automatic logic [11:0] sine_at(input logic [7:0] addr);
    logic [6:0]  off;
    logic [11:0] mag;
    off = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag = quarter_sine(off);
    return addr[7] ? 12'(13'd4096 - {1'b0, mag}) : mag;
  endfunction

  assign lut_addr = phase_acc[PHASE_W-1 -: 8];

`ifdef DDS_QUARTER_WAVE_EN
  assign lut_data = sine_at(lut_addr);
`else
  function automatic logic [255:0][11:0] build_lut();
    logic [255:0][11:0] t;
    for (int i = 0; i < 256; i++) t[i] = sine_at(8'(i));
    return t;
  endfunction

  localparam logic [255:0][11:0] SINE_LUT = build_lut();

  assign lut_data = SINE_LUT[lut_addr];
`endif

  assign tick     = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign div_next = tick ? '0 : div_cnt + DIV_W'(1);
  // Samples change only in the low half of clk_DDS, so they are settled at every rising edge.
  assign load_sample = tick_q[1] & ~clk_DDS;

  // NOTE: the sine ROM is a constant table and has no reset; only the registers around it do.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div_cnt            <= '0;
      clk_DDS            <= 1'b0;
      tick_q             <= '0;
      phase_acc          <= '0;
      sample_amplitude_1 <= 12'd2048;
      sample_amplitude_2 <= 12'd2048;
    end else begin
      div_cnt <= div_next;
      clk_DDS <= (div_next >= DIV_W'(SAMPLE_DIV / 2));
      tick_q  <= {tick_q[0], tick};
      if (tick)        phase_acc          <= phase_acc + FTW;
      if (tick_q[0])   sample_amplitude_1 <= lut_data;
      if (load_sample) sample_amplitude_2 <= sample_amplitude_1;
    end
  end

  assign frame_word = {4'b0011, sample_amplitude_2};
  assign next_bit   = 4'd14 - bit_cnt;

  // Bit 15 of every frame is the constant 0 command bit, so it can be driven before the sample lands.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      spi_cs   <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_sample) begin
            state    <= SHIFT;
            spi_cs   <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= frame_word[15];
            half_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (half_cnt == HC_W'(SCK_HALF - 1)) begin
            half_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state    <= IDLE;
                spi_cs   <= 1'b1;
                spi_mosi <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                spi_mosi <= frame_word[next_bit];
              end
            end
          end else begin
            half_cnt <= half_cnt + HC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_generator.sv
// Self-checking bench for dds_generator: reset, SPI frame decode, sine sequence vs a $sin model.
module tb_dds_generator;

  localparam logic [31:0] FTW_A = 32'h0100_0000;
  localparam logic [31:0] FTW_B = 32'h0100_0000;
  localparam logic [31:0] FTW_C = 32'd4294967;
  localparam logic [31:0] FTW_D = 32'hFFFF_FFFF;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  logic mosi_a, sck_a, cs_a;
  logic mosi_b, sck_b, cs_b;
  logic mosi_c, sck_c, cs_c;
  logic mosi_d, sck_d, cs_d;

  always #4 sysclk = ~sysclk;

  dds_generator #(.PHASE_W(32), .FTW(FTW_A), .SAMPLE_DIV(250), .SCK_HALF(4)) dut_a (
    .sysclk(sysclk), .reset(reset), .spi_mosi(mosi_a), .spi_sck(sck_a), .spi_cs(cs_a));
  dds_generator #(.PHASE_W(32), .FTW(FTW_B), .SAMPLE_DIV(40), .SCK_HALF(1)) dut_b (
    .sysclk(sysclk), .reset(reset), .spi_mosi(mosi_b), .spi_sck(sck_b), .spi_cs(cs_b));
  dds_generator #(.PHASE_W(32), .FTW(FTW_C), .SAMPLE_DIV(40), .SCK_HALF(1)) dut_c (
    .sysclk(sysclk), .reset(reset), .spi_mosi(mosi_c), .spi_sck(sck_c), .spi_cs(cs_c));
  dds_generator #(.PHASE_W(32), .FTW(FTW_D), .SAMPLE_DIV(40), .SCK_HALF(1)) dut_d (
    .sysclk(sysclk), .reset(reset), .spi_mosi(mosi_d), .spi_sck(sck_d), .spi_cs(cs_d));

  int total = 0;
  int bad   = 0;

  logic [11:0] q_b[$];
  logic [11:0] q_c[$];
  logic [11:0] q_d[$];
  bit          logging = 1'b1;

  always @(posedge dut_b.clk_DDS) if (logging) q_b.push_back(dut_b.sample_amplitude_2);
  always @(posedge dut_c.clk_DDS) if (logging) q_c.push_back(dut_c.sample_amplitude_2);
  always @(posedge dut_d.clk_DDS) if (logging) q_d.push_back(dut_d.sample_amplitude_2);

  task automatic check(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference table straight from the defining formula, rounding half away from zero.
  function automatic int ref_lut(input int idx);
    real s;
    int  r;
    s = 2047.0 * $sin(2.0 * 3.141592653589793 * idx / 256.0);
    if (s >= 0.0) r = $rtoi(s + 0.5);
    else          r = -$rtoi(-s + 0.5);
    return 2048 + r;
  endfunction

  // Sample n after reset: the accumulator has advanced n times, modulo 2^32.
  function automatic int ref_sample(input logic [31:0] ftw, input int n);
    logic [31:0] acc;
    acc = ftw * 32'(n);
    return ref_lut(int'(acc[31:24]));
  endfunction

  task automatic wait_cs_fall(input int budget, output int cyc, output bit ok);
    cyc = 0;
    while (!cs_a && cyc < budget) begin @(negedge sysclk); cyc++; end
    while (cs_a && cyc < budget)  begin @(negedge sysclk); cyc++; end
    ok = !cs_a;
  endtask

  // Entered at a negedge where cs is already low; returns at the first negedge with cs high.
  task automatic decode_frame(output logic [15:0] word, output int pulses,
                              output int low_cyc, output int glitches);
    logic prev_sck, prev_mosi;
    word = '0; pulses = 0; low_cyc = 0; glitches = 0;
    prev_sck = 1'b0; prev_mosi = mosi_a;
    while (cs_a == 1'b0 && low_cyc < 1000) begin
      low_cyc++;
      if (sck_a && !prev_sck) begin
        pulses++;
        word = {word[14:0], mosi_a};
      end
      if (sck_a && prev_sck && mosi_a != prev_mosi) glitches++;
      prev_sck  = sck_a;
      prev_mosi = mosi_a;
      @(negedge sysclk);
    end
  endtask

  typedef struct {
    int unit;   // 1 = dut_b (FTW 2^24), 2 = dut_c (default FTW), 3 = dut_d (FTW all ones)
    int n;
    int exp;
  } vec_t;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [14];
    logic [15:0] word;
    int          pulses, low_cyc, glitches, cyc, n_frame, skip, hi, lo, rises, got, mn, mx, xs;
    bit          ok;
    logic        prev;

    vecs = '{'{1, 0, 2048}, '{1, 1, 2098}, '{1, 2, 2148}, '{1, 64, 4095},
             '{1, 128, 2048}, '{1, 192, 1}, '{1, 256, 2048}, '{1, 257, 2098},
             '{2, 0, 2048}, '{2, 250, 4094}, '{2, 1000, 1998},
             '{3, 1, 1998}, '{3, 2, 1998}, '{3, 7, 1998}};

    // Reset state
    reset = 1'b0;
    #50;
    check("rst_cs", cs_a, 1);
    check("rst_sck", sck_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_sample", dut_a.sample_amplitude_2, 2048);
    check("rst_clk_dds", dut_a.clk_DDS, 0);
    #50;
    @(negedge sysclk);
    reset = 1'b1;

    // First frame: cs falls three cycles after the first tick (div_cnt 249 -> 2)
    wait_cs_fall(2000, cyc, ok);
    check("first_cs_seen", ok, 1);
    check("first_cs_fall_cycle", cyc, 252);
    check("first_sample_at_cs", dut_a.sample_amplitude_2, 2098);
    decode_frame(word, pulses, low_cyc, glitches);
    check("frame1_word", word, {4'b0011, 12'd2098});
    check("frame1_sck_pulses", pulses, 16);
    check("frame1_cs_low_cycles", low_cyc, 128);
    check("frame1_mosi_stable", glitches, 0);
    check("frame1_sck_idle", sck_a, 0);

    // A few randomly chosen later frames checked against the model
    n_frame = 1;
    for (int k = 0; k < 3; k++) begin
      skip = $urandom_range(0, 2);
      for (int s = 0; s < skip; s++) wait_cs_fall(600, cyc, ok);
      wait_cs_fall(600, cyc, ok);
      n_frame += skip + 1;
      check("rand_frame_seen", ok, 1);
      decode_frame(word, pulses, low_cyc, glitches);
      check("rand_frame_word", word, {4'b0011, 12'(ref_sample(FTW_A, n_frame))});
      check("rand_frame_pulses", pulses, 16);
      check("rand_frame_low", low_cyc, 128);
    end

    // Sample clock: 250 sysclk period, 125 high -> 500 kS/s at 125 MHz
    cyc = 0;
    while (dut_a.clk_DDS && cyc < 600)  begin @(negedge sysclk); cyc++; end
    while (!dut_a.clk_DDS && cyc < 600) begin @(negedge sysclk); cyc++; end
    hi = 0; lo = 0;
    while (dut_a.clk_DDS && hi < 600)  begin @(negedge sysclk); hi++; end
    while (!dut_a.clk_DDS && lo < 600) begin @(negedge sysclk); lo++; end
    check("clk_dds_high_cycles", hi, 125);
    check("clk_dds_period_cycles", hi + lo, 250);

    // Let the fast instances log at least 1001 samples
    cyc = 0;
    while (q_c.size() < 1001 && cyc < 60000) begin @(negedge sysclk); cyc++; end
    check("log_complete", (q_c.size() >= 1001 && q_b.size() >= 260 && q_d.size() >= 32), 1);

    foreach (vecs[i]) begin
      got = -1;
      case (vecs[i].unit)
        1: if (vecs[i].n < q_b.size()) got = q_b[vecs[i].n];
        2: if (vecs[i].n < q_c.size()) got = q_c[vecs[i].n];
        default: if (vecs[i].n < q_d.size()) got = q_d[vecs[i].n];
      endcase
      check($sformatf("vec%0d_u%0d_n%0d", i, vecs[i].unit, vecs[i].n), got, vecs[i].exp);
    end

    for (int n = 0; n < 260 && n < q_b.size(); n++)
      check($sformatf("ftw24_n%0d", n), q_b[n], ref_sample(FTW_B, n));
    for (int n = 0; n < 32 && n < q_d.size(); n++)
      check($sformatf("ftw_ones_n%0d", n), q_d[n], ref_sample(FTW_D, n));

    mn = 4096; mx = -1; xs = 0;
    for (int n = 0; n < 1001 && n < q_c.size(); n++) begin
      if ($isunknown(q_c[n])) xs++;
      if (int'(q_c[n]) < mn) mn = q_c[n];
      if (int'(q_c[n]) > mx) mx = q_c[n];
      check($sformatf("ftw_def_n%0d", n), q_c[n], ref_sample(FTW_C, n));
    end
    check("ftw_def_no_x", xs, 0);
    check("ftw_def_min", mn, 1);
    check("ftw_def_max", mx, 4095);

    // Reset during bit 8 of a frame: outputs drop to idle at once, then a clean restart
    logging = 1'b0;
    wait_cs_fall(600, cyc, ok);
    check("mid_cs_seen", ok, 1);
    rises = 0; prev = sck_a; cyc = 0;
    while (rises < 8 && cyc < 500) begin
      @(negedge sysclk);
      cyc++;
      if (sck_a && !prev) rises++;
      prev = sck_a;
    end
    check("mid_reached_bit8", rises, 8);
    check("mid_cs_low_before", cs_a, 0);
    #1 reset = 1'b0;
    #1;
    check("mid_cs_async", cs_a, 1);
    check("mid_sck_async", sck_a, 0);
    check("mid_sample_async", dut_a.sample_amplitude_2, 2048);
    repeat ($urandom_range(2, 5)) @(negedge sysclk);
    reset = 1'b1;
    wait_cs_fall(2000, cyc, ok);
    check("restart_cs_fall_cycle", cyc, 252);
    decode_frame(word, pulses, low_cyc, glitches);
    check("restart_word", word, {4'b0011, 12'd2098});
    check("restart_pulses", pulses, 16);
    check("restart_low", low_cyc, 128);
    check("restart_mosi_stable", glitches, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
